// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional signed-overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage : serial_addsub_pkg

// File: rtl/serial_fas_cell.sv
// Combinational 1-bit full adder / full borrow-subtractor cell.
module serial_fas_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    // In subtract mode cin/cout carry the borrow rather than the carry.
    assign cout = (a_ns == OP_ADD) ? ((a & b) | (cin & axb))
                                   : ((~a & b) | (~axb & cin));

endmodule : serial_fas_cell

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first N-bit adder/subtractor with a start/busy/done handshake.
// Defining SERIAL_ADDSUB_OVF_EN adds the ovf (signed overflow) output.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         a_ns,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t         state_q;
    state_t         state_d;
    logic           load;
    logic           shift;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic           op_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;
    logic           bit_s;
    logic           bit_c;
    logic           last_bit;

    assign last_bit = (cnt_q == LAST_BIT);

    serial_fas_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .a_ns (op_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, handshake outputs and serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            op_q    <= OP_SUB;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy    <= (state_q == RUN);
            done    <= (state_q == DONE);
            if (load) begin
                a_sh    <= a;
                b_sh    <= b;
                op_q    <= a_ns;
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end
            if (shift) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                result  <= {bit_s, result[N-1:1]};
                carry_q <= bit_c;
                if (last_bit) begin
                    cout <= bit_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // Carry (or borrow) into the MSB differing from the one out of it.
                    ovf  <= carry_q ^ bit_c;
`endif
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Directed, table-driven bench for serial_addsub (N=8), with corner-case sequences.
module tb_serial_addsub;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         a_ns;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs [11];

    serial_addsub #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .a_ns   (a_ns),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Wait (bounded) for done; latency counted from the accept edge, lat=-1 on timeout.
    task automatic wait_done(input int acc, output int lat, output int nb);
        lat = -1;
        nb  = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] er,
                                input logic ec, input logic eo);
        check({tag, " result"}, int'(result), int'(er));
        check({tag, " cout"}, int'(cout), int'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, " ovf"}, int'(ovf), int'(eo));
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
    endtask

    task automatic do_op(input string tag, input vec_t v);
        int acc, lat, nb;
        @(negedge clk);
        a = v.a; b = v.b; a_ns = v.op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        wait_done(acc, lat, nb);
        check({tag, " latency"}, lat, N + 1);
        check({tag, " busy cycles"}, nb, N);
        check_result(tag, v.res, v.c, v.o);
        @(negedge clk);
        check({tag, " done single pulse"}, int'(done), 0);
    endtask

    // Watch a window for any stray done/busy activity.
    task automatic quiet_window(input string tag, input int len);
        int nd, nbz;
        nd = 0; nbz = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nbz++;
        end
        check({tag, " stray done"}, nd, 0);
        check({tag, " stray busy"}, nbz, 0);
    endtask

    initial begin
        int acc, acc2, lat, nb;
        vec_t v;

        //            a    b    op   res  c     o
        vecs[0]  = '{8'd100, 8'd27,  1'b1, 8'd127, 1'b0, 1'b0};
        vecs[1]  = '{8'd200, 8'd100, 1'b1, 8'd44,  1'b1, 1'b0};
        vecs[2]  = '{8'd127, 8'd1,   1'b1, 8'd128, 1'b0, 1'b1};
        vecs[3]  = '{8'd5,   8'd9,   1'b0, 8'd252, 1'b1, 1'b0};
        vecs[4]  = '{8'd9,   8'd5,   1'b0, 8'd4,   1'b0, 1'b0};
        vecs[5]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0};
        vecs[6]  = '{8'd255, 8'd1,   1'b1, 8'd0,   1'b1, 1'b0};
        vecs[7]  = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1};
        vecs[8]  = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0};
        vecs[9]  = '{8'd255, 8'd255, 1'b1, 8'd254, 1'b1, 1'b0};
        vecs[10] = '{8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; a_ns = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check_result("reset", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start pulsed mid-RUN with different operands is ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd20; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        @(negedge clk);
        @(negedge clk);
        a = 8'd99; b = 8'd200; a_ns = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(acc, lat, nb);
        check("ignore latency", lat, N + 1);
        check_result("ignore", 8'd30, 1'b0, 1'b0);
        quiet_window("ignore after", 2 * N);

        // Reset mid-RUN discards the operation; start under reset is ignored.
        @(negedge clk);
        a = 8'd50; b = 8'd60; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check_result("midrst", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        quiet_window("midrst after", 2 * N);
        v = '{8'd11, 8'd22, 1'b1, 8'd33, 1'b0, 1'b0};
        do_op("post rst", v);

        // start held through DONE gives a back-to-back operation.
        @(negedge clk);
        a = 8'd3; b = 8'd4; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 8'd200; b = 8'd1; a_ns = 1'b0;
        acc = cyc;
        wait_done(acc, lat, nb);
        start = 1'b0;
        acc2 = cyc;
        check("b2b first latency", lat, N + 1);
        check_result("b2b first", 8'd7, 1'b0, 1'b0);
        wait_done(acc2, lat, nb);
        check("b2b done spacing", lat, N + 1);
        check("b2b busy cycles", nb, N);
        check_result("b2b second", 8'd199, 1'b0, 1'b0);
        quiet_window("b2b after", N + 3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_serial_addsub

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter N, default 8: operand/result width in bits, legal N >= 2.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation, sampled on clk.
REQ-005 a  input  N  operand A, sampled only when start is accepted.
REQ-006 b  input  N  operand B, sampled only when start is accepted.
REQ-007 a_ns  input  1  operation select, sampled with operands: 1 = add (A+B), 0 = subtract (A-B).
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when result and cout are valid.
REQ-010 result  output  N  sum or difference, modulo 2^N.
REQ-011 cout  output  1  add: carry out of bit N-1; subtract: borrow out of bit N-1 (1 = A < B unsigned).

Function
REQ-012 Processing SHALL be bit-serial, LSB first, one bit per clk, through a single 1-bit adder/subtractor cell plus one carry/borrow flop.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch a, b, a_ns, clear carry/borrow to 0, clear bit counter, go to RUN.
REQ-015 RUN: each cycle SHALL compute bit i, shift it into result, update carry/borrow, increment counter; after bit N-1 go to DONE.
REQ-016 Latency: start accepted at edge k SHALL give done=1 in the cycle after edge k+N+1; busy=1 in cycles after edges k+1..k+N.
REQ-017 DONE: done=1 for exactly one cycle; next state IDLE, or RUN if start=1 in that cycle (back-to-back, operands latched as in REQ-014).
REQ-018 start while in RUN SHALL be ignored; latched operands and op SHALL not change.
REQ-019 result and cout SHALL hold their last completed values in IDLE until the next operation's DONE; intermediate shift contents may be visible on result only while busy=1.
REQ-020 Subtract SHALL be true borrow subtraction: diff bit = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
REQ-021 Add: sum bit = a^b^cin, cout = (a&b) | (cin&(a^b)).
REQ-022 Bit counter width SHALL be $clog2(N); counter SHALL not wrap past N-1 within an operation.

Reset
REQ-023 rst=1 at any edge, including mid-RUN, SHALL force IDLE, busy=0, done=0, result=0, cout=0, carry flop=0, counter=0; the in-flight operation is discarded without done.
REQ-024 start asserted together with rst SHALL be ignored.

Configuration
REQ-025 Macro SERIAL_ADDSUB_OVF_EN defined: extra output ovf (1 bit) = two's-complement signed overflow of the completed operation, valid and held like cout, reset to 0.
REQ-026 Macro undefined: port ovf and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package serial_addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and op constants OP_ADD=1'b1, OP_SUB=1'b0.
REQ-028 One sub-module, serial_fas_cell: combinational 1-bit cell (a, b, cin, a_ns -> s, cout) per REQ-020/021.

Verification (N=8)
REQ-029 Add 100+27 -> done after 9 cycles, result=127, cout=0 (ovf=0).
REQ-030 Add 200+100 -> result=44, cout=1; add 127+1 -> result=128, cout=0, ovf=1 when enabled.
REQ-031 Sub 5-9 -> result=252, cout=1; sub 9-5 -> result=4, cout=0.
REQ-032 start pulsed at RUN cycle 3 with new operands -> ignored, first result unchanged, single done.
REQ-033 rst at RUN cycle 4 -> next cycle busy=0, result=0, no done; new start then completes normally.
REQ-034 start held high through DONE -> back-to-back operation, done pulses exactly N+1 cycles apart.
